lsu_sequencer: RTL and testbench
================================

// Module: lsu_sequencer
// PURPOSE
//  Multi-cycle load/store sequencer for the MEM stage. Takes the decoded memory op (Common instType)
//  plus ALU address and rs2 data, runs one request/grant/response transaction on the data bus,
//  aligns and extends load data, and raises misaligned/access-fault exceptions.
//  Stalls the pipeline for the whole access and returns a one-cycle done pulse to writeback/trap logic.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in WAIT before the access is declared an access fault (>=1)
// PORTS
//  clk_i          in   1   clock, all state updates on rising edge
//  rst_ni         in   1   synchronous reset, active-low
//  start_i        in   1   MEM-stage instruction valid; sampled only in IDLE
//  inst_type_i    in   Common instType  MEM_NOP/LB/LH/LW/LBU/LHU/SB/SH/SW
//  addr_i         in   32  effective byte address (ALU result)
//  wdata_i        in   32  store data (rs2)
//  stall_o        out  1   hold upstream pipeline stages
//  done_o         out  1   one-cycle pulse: access finished (result or exception)
//  rdata_o        out  32  aligned, sign/zero-extended load result; valid with done_o
//  exc_o          out  1   exception with done_o
//  exc_cause_o    out  32  mcause: 4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault
//  exc_tval_o     out  32  faulting byte address (addr_i as captured)
//  bus_req_o      out  1   bus request; held until bus_gnt_i
//  bus_we_o       out  1   1 = store
//  bus_addr_o     out  32  {addr[31:2],2'b00}
//  bus_be_o       out  4   byte enables
//  bus_wdata_o    out  32  lane-replicated store data
//  bus_gnt_i      in   1   request accepted this cycle
//  bus_rvalid_i   in   1   response valid (loads and stores)
//  bus_rdata_i    in   32  response data
//  bus_err_i      in   1   response error; qualified by bus_rvalid_i
// BEHAVIOUR
//  - Reset (rst_ni=0 at edge): state IDLE, timeout counter 0; all outputs 0. Reset mid-access abandons it:
//    bus_req_o low from next cycle, no done_o, late bus_rvalid_i ignored in IDLE.
//  - States IDLE -> REQ -> WAIT -> DONE -> IDLE; IDLE -> DONE directly on misalignment.
//  - IDLE: start_i=1 & inst_type_i!=MEM_NOP captures type, addr, wdata; stall_o=1 combinationally this cycle.
//    Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0) -> DONE with exc; no bus traffic. Else -> REQ.
//    start_i with MEM_NOP: no action, stall_o=0.
//  - REQ: bus_req_o=1, bus_we_o/addr/be/wdata stable from captured regs; bus_gnt_i=1 -> WAIT.
//  - WAIT: bus_req_o=0; counter increments each cycle. bus_rvalid_i=1 -> capture rdata/err, -> DONE.
//    Counter reaching TIMEOUT_CYCLES without rvalid -> access fault, -> DONE. gnt and rvalid same
//    cycle are not legal; rvalid is only honoured in WAIT.
//  - DONE: done_o=1, stall_o=0 (pipeline advances this edge), exc_o/cause/tval valid; -> IDLE. Counter cleared.
//  - stall_o = 1 in REQ and WAIT, and in IDLE per above. start_i ignored outside IDLE.
//  - Min latency: start cycle 0, req cycle 1 (gnt), rvalid cycle 2, done_o cycle 3.
//  - Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; loads 4'b1111.
//  - Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
//  - Load extract: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW as is.
//  - Error/timeout: cause 5 for loads, 7 for stores; rdata_o=0 when exc_o=1. Outputs hold 0 outside DONE.
// TESTING
//  - LB addr 0x1003, rdata 0x80123456, gnt/rvalid immediate -> be 4'b1111, done cycle 3, rdata_o 0xFFFFFF80.
//  - LHU addr 0x0002, rdata 0xBEEF1234 -> rdata_o 0x0000BEEF, exc_o 0; LH same -> 0xFFFFBEEF.
//  - SB addr 0x0101 wdata 0x000000AB, gnt delayed 3 cycles -> req held 4 cycles, be 4'b0010, wdata 0xABABABAB.
//  - LW addr 0x0006 -> no bus_req_o, done_o next cycle, exc_o 1, cause 4, tval 0x6; SH addr 0x1 -> cause 6.
//  - SW, gnt then no rvalid -> done_o after TIMEOUT_CYCLES WAIT cycles, cause 7; LW rvalid+err -> cause 5.
//  - rst_ni=0 during WAIT, then rvalid -> no done_o, all outputs 0, next LW completes normally.

Source files
------------

// File: rtl/lsu_sequencer_if.sv
// Data-bus interface between the load/store sequencer (master) and memory (slave).
// Request/grant handshake for the address phase, rvalid/err for the response.
interface lsu_sequencer_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/lsu_sequencer.sv
// MEM-stage load/store sequencer: one bus transaction per memory op, load
// alignment/extension, misaligned and access-fault exceptions, pipeline stall.
// Memory op encoding: 0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW.
module lsu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [3:0]      inst_type_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     wdata_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [31:0]     rdata_o,
  output logic            exc_o,
  output logic [31:0]     exc_cause_o,
  output logic [31:0]     exc_tval_o,
  lsu_sequencer_if.master bus
);

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  // The counter only needs to reach TIMEOUT_CYCLES-1: that value in WAIT is the last wait cycle.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       type_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;
  logic [31:0]      rdata_reg;
  logic [31:0]      cause_reg;
  logic             exc_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic        in_valid, in_store, in_misaligned;
  logic        cur_store, in_req, timeout_hit;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;

  // Decode of the incoming op; unknown encodings are treated like MEM_NOP.
  assign in_valid      = start_i && (inst_type_i inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU,
                                                         MEM_LHU, MEM_SB, MEM_SH, MEM_SW});
  assign in_store      = inst_type_i inside {MEM_SB, MEM_SH, MEM_SW};
  assign in_misaligned = ((inst_type_i inside {MEM_LH, MEM_LHU, MEM_SH}) && addr_i[0]) ||
                         ((inst_type_i inside {MEM_LW, MEM_SW}) && (addr_i[1:0] != 2'b00));

  assign cur_store   = type_reg inside {MEM_SB, MEM_SH, MEM_SW};
  assign in_req      = (state_reg == S_REQ);
  assign timeout_hit = (cnt_reg == CNT_LAST);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state and stall decode.
  always_comb begin
    state_next = state_reg;
    stall_o    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          stall_o    = 1'b1;
          state_next = in_misaligned ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (bus.gnt) state_next = S_WAIT;
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (bus.rvalid || timeout_hit) state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Load alignment: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    load_byte = bus.rdata[{addr_reg[1:0], 3'b000} +: 8];
    load_half = addr_reg[1] ? bus.rdata[31:16] : bus.rdata[15:0];
    case (type_reg)
      MEM_LB:  load_data = {{24{load_byte[7]}}, load_byte};
      MEM_LBU: load_data = {24'h0, load_byte};
      MEM_LH:  load_data = {{16{load_half[15]}}, load_half};
      MEM_LHU: load_data = {16'h0, load_half};
      default: load_data = bus.rdata;
    endcase
  end

  // Per-lane byte enables and replicated store data.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign store_be[gi] = (type_reg == MEM_SB) ? (addr_reg[1:0] == LANE) :
                          (type_reg == MEM_SH) ? (addr_reg[1] == LANE[1]) : 1'b1;
    assign store_wdata[8*gi +: 8] = (type_reg == MEM_SB) ? wdata_reg[7:0] :
                                    (type_reg == MEM_SH) ? wdata_reg[8*(gi%2) +: 8] :
                                                           wdata_reg[8*gi +: 8];
  end

  // Operand capture, response capture, timeout counter and exception status.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      type_reg  <= MEM_NOP;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      cause_reg <= '0;
      exc_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            type_reg  <= inst_type_i;
            addr_reg  <= addr_i;
            wdata_reg <= wdata_i;
            rdata_reg <= '0;
            exc_reg   <= in_misaligned;
            cause_reg <= in_store ? 32'd6 : 32'd4;
            cnt_reg   <= '0;
          end
        end
        S_WAIT: begin
          if (bus.rvalid) begin
            exc_reg   <= bus.err;
            cause_reg <= cur_store ? 32'd7 : 32'd5;
            rdata_reg <= (bus.err || cur_store) ? 32'h0 : load_data;
          end else if (timeout_hit) begin
            exc_reg   <= 1'b1;
            cause_reg <= cur_store ? 32'd7 : 32'd5;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_DONE: cnt_reg <= '0;
        default: ;
      endcase
    end
  end

  // Bus drive: only meaningful while requesting, zero otherwise.
  assign bus.req   = in_req;
  assign bus.we    = in_req && cur_store;
  assign bus.addr  = in_req ? {addr_reg[31:2], 2'b00} : 32'h0;
  assign bus.be    = in_req ? store_be : 4'h0;
  assign bus.wdata = (in_req && cur_store) ? store_wdata : 32'h0;

  // Result outputs are qualified by DONE so they read as zero at all other times.
  assign done_o      = (state_reg == S_DONE);
  assign exc_o       = done_o && exc_reg;
  assign rdata_o     = (done_o && !exc_reg) ? rdata_reg : 32'h0;
  assign exc_cause_o = exc_o ? cause_reg : 32'h0;
  assign exc_tval_o  = exc_o ? addr_reg : 32'h0;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: acts as the bus slave, pushes the expected
// completion of each access to a scoreboard and pops it when done_o fires.
module tb_lsu_sequencer;

  localparam int TO = 255;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  typedef struct {
    logic [31:0] rdata;
    logic        exc;
    logic [31:0] cause;
    logic [31:0] tval;
    int          lat;
    int          reqs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  inst_type = MEM_NOP;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall, done, exc;
  logic [31:0] rdata, cause, tval;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  lsu_sequencer_if bus_if ();

  lsu_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .inst_type_i(inst_type),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .stall_o    (stall),
    .done_o     (done),
    .rdata_o    (rdata),
    .exc_o      (exc),
    .exc_cause_o(cause),
    .exc_tval_o (tval),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic ex, input logic [31:0] cs,
                              input logic [31:0] tv, input int lat, input int reqs);
    exp_t e;
    e.rdata = rd; e.exc = ex; e.cause = cs; e.tval = tv; e.lat = lat; e.reqs = reqs;
    return e;
  endfunction

  // One access: start in cycle 0, grant after gnt_dly request cycles, respond rv_dly
  // cycles into WAIT (rv_dly < 0: never respond), then check the popped expectation.
  task automatic do_access(input string name, input logic [3:0] t, input logic [31:0] a,
                           input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                           input logic [31:0] rd, input logic err_in, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input exp_t e);
    exp_t got;
    int   cyc, reqs, gnt_cyc;
    bit   seen;
    @(negedge clk);
    start = 1'b1; inst_type = t; addr = a; wdata = wd;
    sb_q.push_back(e);
    #1 check({name, "_stall_idle"}, 32'(stall), 32'd1);
    @(negedge clk);
    start = 1'b0; inst_type = MEM_NOP; addr = 32'h0; wdata = 32'h0;
    cyc = 1; reqs = 0; gnt_cyc = -1; seen = 1'b0;
    while (!seen && cyc <= TO + 100) begin
      bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0; bus_if.err = 1'b0; bus_if.rdata = 32'h0;
      #1;
      if (done) begin
        seen = 1'b1;
        got = sb_q.pop_front();
        check({name, "_latency"}, 32'(cyc), 32'(got.lat));
        check({name, "_req_cycles"}, 32'(reqs), 32'(got.reqs));
        check({name, "_stall_done"}, 32'(stall), 32'd0);
        check({name, "_rdata"}, rdata, got.rdata);
        check({name, "_exc"}, 32'(exc), 32'(got.exc));
        check({name, "_cause"}, cause, got.cause);
        check({name, "_tval"}, tval, got.tval);
      end else begin
        if (bus_if.req) begin
          reqs++;
          if (reqs == 1) begin
            check({name, "_bus_addr"}, bus_if.addr, {a[31:2], 2'b00});
            check({name, "_bus_be"}, 32'(bus_if.be), 32'(exp_be));
            check({name, "_bus_we"}, 32'(bus_if.we), 32'(t inside {MEM_SB, MEM_SH, MEM_SW}));
            if (t inside {MEM_SB, MEM_SH, MEM_SW})
              check({name, "_bus_wdata"}, bus_if.wdata, exp_wdata);
          end
          if (reqs - 1 == gnt_dly) begin
            bus_if.gnt = 1'b1;
            gnt_cyc = cyc;
          end
        end else if (gnt_cyc >= 0 && rv_dly >= 0 && cyc == gnt_cyc + 1 + rv_dly) begin
          bus_if.rvalid = 1'b1; bus_if.rdata = rd; bus_if.err = err_in;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    if (!seen && sb_q.size() > 0) got = sb_q.pop_front();
    @(negedge clk);
    #1;
    check({name, "_done_pulse"}, 32'(done), 32'd0);
    check({name, "_rdata_after"}, rdata, 32'h0);
  endtask

  initial begin
    bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = 32'h0; bus_if.err = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_exc", 32'(exc), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_cause", cause, 32'h0);
    check("rst_tval", tval, 32'h0);
    check("rst_req", 32'(bus_if.req), 32'd0);
    check("rst_be", 32'(bus_if.be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MEM_NOP with start: no stall, no activity
    @(negedge clk);
    start = 1'b1; inst_type = MEM_NOP; addr = 32'h4;
    #1 check("nop_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("nop_req", 32'(bus_if.req), 32'd0);
    check("nop_done", 32'(done), 32'd0);

    // Loads with lane selection and extension
    do_access("lb_1003", MEM_LB, 32'h1003, 32'h0, 0, 0, 32'h80123456, 1'b0, 4'hF, 32'h0,
              mk(32'hFFFFFF80, 1'b0, 32'h0, 32'h0, 3, 1));
    do_access("lb_1001", MEM_LB, 32'h1001, 32'h0, 0, 0, 32'h80123456, 1'b0, 4'hF, 32'h0,
              mk(32'h00000034, 1'b0, 32'h0, 32'h0, 3, 1));
    do_access("lbu_1003", MEM_LBU, 32'h1003, 32'h0, 0, 0, 32'h80123456, 1'b0, 4'hF, 32'h0,
              mk(32'h00000080, 1'b0, 32'h0, 32'h0, 3, 1));
    do_access("lhu_0002", MEM_LHU, 32'h0002, 32'h0, 0, 0, 32'hBEEF1234, 1'b0, 4'hF, 32'h0,
              mk(32'h0000BEEF, 1'b0, 32'h0, 32'h0, 3, 1));
    do_access("lh_0002", MEM_LH, 32'h0002, 32'h0, 0, 0, 32'hBEEF1234, 1'b0, 4'hF, 32'h0,
              mk(32'hFFFFBEEF, 1'b0, 32'h0, 32'h0, 3, 1));
    do_access("lh_0000", MEM_LH, 32'h0000, 32'h0, 0, 0, 32'h12348001, 1'b0, 4'hF, 32'h0,
              mk(32'hFFFF8001, 1'b0, 32'h0, 32'h0, 3, 1));
    do_access("lw_slow", MEM_LW, 32'h0010, 32'h0, 1, 2, 32'hCAFEF00D, 1'b0, 4'hF, 32'h0,
              mk(32'hCAFEF00D, 1'b0, 32'h0, 32'h0, 6, 2));

    // Stores: lane enables and replicated data
    do_access("sb_0101", MEM_SB, 32'h0101, 32'h000000AB, 3, 0, 32'h0, 1'b0, 4'b0010, 32'hABABABAB,
              mk(32'h0, 1'b0, 32'h0, 32'h0, 6, 4));
    do_access("sh_0002", MEM_SH, 32'h0002, 32'h1234BEEF, 0, 0, 32'h0, 1'b0, 4'b1100, 32'hBEEFBEEF,
              mk(32'h0, 1'b0, 32'h0, 32'h0, 3, 1));

    // Misaligned: no bus traffic, done in the following cycle
    do_access("lw_mis", MEM_LW, 32'h0006, 32'h0, 0, 0, 32'h0, 1'b0, 4'hF, 32'h0,
              mk(32'h0, 1'b1, 32'd4, 32'h6, 1, 0));
    do_access("sh_mis", MEM_SH, 32'h0001, 32'h5555, 0, 0, 32'h0, 1'b0, 4'h0, 32'h0,
              mk(32'h0, 1'b1, 32'd6, 32'h1, 1, 0));
    do_access("lhu_mis", MEM_LHU, 32'h0003, 32'h0, 0, 0, 32'h0, 1'b0, 4'hF, 32'h0,
              mk(32'h0, 1'b1, 32'd4, 32'h3, 1, 0));

    // Store timeout after TO wait cycles, load bus error
    do_access("sw_timeout", MEM_SW, 32'h0020, 32'h12345678, 0, -1, 32'h0, 1'b0, 4'hF, 32'h12345678,
              mk(32'h0, 1'b1, 32'd7, 32'h20, 2 + TO, 1));
    do_access("lw_err", MEM_LW, 32'h0040, 32'h0, 0, 0, 32'hDEADBEEF, 1'b1, 4'hF, 32'h0,
              mk(32'h0, 1'b1, 32'd5, 32'h40, 3, 1));

    // Reset during WAIT abandons the access; a late rvalid is ignored
    @(negedge clk);
    start = 1'b1; inst_type = MEM_LW; addr = 32'h0010;
    @(negedge clk);
    start = 1'b0; inst_type = MEM_NOP; addr = 32'h0;
    #1 check("rstw_req", 32'(bus_if.req), 32'd1);
    bus_if.gnt = 1'b1;
    @(negedge clk);
    bus_if.gnt = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.rvalid = 1'b1; bus_if.rdata = 32'h11112222;
    #1;
    check("rstw_done", 32'(done), 32'd0);
    check("rstw_req_low", 32'(bus_if.req), 32'd0);
    check("rstw_stall", 32'(stall), 32'd0);
    check("rstw_rdata", rdata, 32'h0);
    check("rstw_exc", 32'(exc), 32'd0);
    @(negedge clk);
    bus_if.rvalid = 1'b0; bus_if.rdata = 32'h0;
    #1 check("rstw_late_rvalid", 32'(done), 32'd0);

    do_access("lw_after_rst", MEM_LW, 32'h0008, 32'h0, 0, 0, 32'hA5A55A5A, 1'b0, 4'hF, 32'h0,
              mk(32'hA5A55A5A, 1'b0, 32'h0, 32'h0, 3, 1));

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
